// File: rtl/mem_responder_if.sv
// Request/response bundle between the processor core (master) and the shared memory responder (slave).
// Carries the instruction-fetch port and the data port.
interface mem_responder_if;
    logic        iReq;
    logic [31:0] iaddr;
    logic [31:0] inst;
    logic        iAck;

    logic        dReq;
    logic        dWr;
    logic [1:0]  dSize;
    logic [31:0] daddr;
    logic [31:0] dwData;
    logic [31:0] drData;
    logic        dAck;
    logic        dErr;

    modport master (
        output iReq, iaddr, dReq, dWr, dSize, daddr, dwData,
        input  inst, iAck, drData, dAck, dErr
    );

    modport slave (
        input  iReq, iaddr, dReq, dWr, dSize, daddr, dwData,
        output inst, iAck, drData, dAck, dErr
    );
endinterface

// File: rtl/mem_responder.sv
// Single-ported, big-endian memory serving the fetch and data ports one request at a time.
// Each request completes after a fixed, parameterised latency.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            pcRst,
    mem_responder_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, ACK} stateT;

    logic [31:0] mem [DEPTH_WORDS];

    stateT       state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic [AW+1:0] reqAddr, reqAddrNext;
    logic        reqWr, reqWrNext;
    logic [1:0]  reqSize, reqSizeNext;
    logic [31:0] reqWData, reqWDataNext;

    logic [31:0] instReg, instNext;
    logic [31:0] drDataReg, drDataNext;
    logic        iAckReg, iAckNext;
    logic        dAckReg, dAckNext;
    logic        dErrReg, dErrNext;

    logic [31:0] rdWord;
    logic [31:0] loadData;
    logic [31:0] wrMask;
    logic [31:0] wrBits;
    logic [4:0]  laneShift;
    logic        misaligned;
    logic        memWe;

    // Address bits above the array size wrap and are intentionally dropped.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.iaddr[31:AW+2], bus.daddr[31:AW+2]};

    assign rdWord     = mem[reqAddr[AW+1:2]];
    assign misaligned = (reqSize == 2'b01 && reqAddr[0]) ||
                        (reqSize[1] && reqAddr[1:0] != 2'b00);
    // Big-endian: byte offset 0 lives in bits [31:24], so the shift is (3 - offset) * 8.
    assign laneShift  = {~reqAddr[1:0], 3'b000};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        loadData = rdWord;
        wrMask   = 32'hFFFF_FFFF;
        wrBits   = reqWData;
        case (reqSize)
            2'b00: begin
                loadData = {24'd0, 8'(rdWord >> laneShift)};
                wrMask   = 32'h0000_00FF << laneShift;
                wrBits   = {4{reqWData[7:0]}};
            end
            2'b01: begin
                loadData = reqAddr[1] ? {16'd0, rdWord[15:0]} : {16'd0, rdWord[31:16]};
                wrMask   = reqAddr[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                wrBits   = {2{reqWData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        reqAddrNext  = reqAddr;
        reqWrNext    = reqWr;
        reqSizeNext  = reqSize;
        reqWDataNext = reqWData;
        instNext     = instReg;
        drDataNext   = drDataReg;
        dErrNext     = dErrReg;
        iAckNext     = 1'b0;
        dAckNext     = 1'b0;
        memWe        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.dReq) begin
                    reqAddrNext  = bus.daddr[AW+1:0];
                    reqWrNext    = bus.dWr;
                    reqSizeNext  = bus.dSize;
                    reqWDataNext = bus.dwData;
                    cntNext      = CNT_INIT;
                    stateNext    = BUSY_D;
                end else if (bus.iReq) begin
                    reqAddrNext  = bus.iaddr[AW+1:0];
                    cntNext      = CNT_INIT;
                    stateNext    = BUSY_I;
                end
            end
            BUSY_D: begin
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    dAckNext   = 1'b1;
                    dErrNext   = misaligned;
                    drDataNext = (misaligned || reqWr) ? 32'd0 : loadData;
                    memWe      = reqWr && !misaligned;
                    stateNext  = ACK;
                end
            end
            BUSY_I: begin
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    iAckNext  = 1'b1;
                    instNext  = rdWord;
                    stateNext = ACK;
                end
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge pcRst) begin
        if (!pcRst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            reqAddr   <= '0;
            reqWr     <= 1'b0;
            reqSize   <= 2'b00;
            reqWData  <= 32'd0;
            instReg   <= 32'd0;
            drDataReg <= 32'd0;
            iAckReg   <= 1'b0;
            dAckReg   <= 1'b0;
            dErrReg   <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            reqAddr   <= reqAddrNext;
            reqWr     <= reqWrNext;
            reqSize   <= reqSizeNext;
            reqWData  <= reqWDataNext;
            instReg   <= instNext;
            drDataReg <= drDataNext;
            iAckReg   <= iAckNext;
            dAckReg   <= dAckNext;
            dErrReg   <= dErrNext;
        end
    end

    // NOTE: the array has no reset; contents survive pcRst, and the async state reset blocks the write.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[reqAddr[AW+1:2]] <= (rdWord & ~wrMask) | (wrBits & wrMask);
        end
    end

    assign bus.inst   = instReg;
    assign bus.iAck   = iAckReg;
    assign bus.drData = drDataReg;
    assign bus.dAck   = dAckReg;
    assign bus.dErr   = dErrReg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus randomized traffic
// checked against a byte-array memory model.
module tb_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int BYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic pcRst;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .pcRst (pcRst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] memB [BYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned wrapA(input logic [31:0] a);
        return a % BYTES;
    endfunction

    function automatic bit modelMis(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd1) return (a % 2) != 0;
        if (size >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelWord(input logic [31:0] a);
        int unsigned b = wrapA(a) & ~32'd3;
        return {memB[b], memB[b+1], memB[b+2], memB[b+3]};
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic [31:0] a);
        int unsigned b = wrapA(a);
        if (modelMis(size, a)) return 32'd0;
        case (size)
            2'd0:    return {24'd0, memB[b]};
            2'd1:    return {16'd0, memB[b], memB[b+1]};
            default: return modelWord(a);
        endcase
    endfunction

    task automatic modelStore(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
        int unsigned b = wrapA(a);
        if (modelMis(size, a)) return;
        case (size)
            2'd0: memB[b] = d[7:0];
            2'd1: begin memB[b] = d[15:8]; memB[b+1] = d[7:0]; end
            default: begin
                memB[b] = d[31:24]; memB[b+1] = d[23:16];
                memB[b+2] = d[15:8]; memB[b+3] = d[7:0];
            end
        endcase
    endtask

    // Starts with the DUT idle; returns with the DUT idle again one edge after the ack cycle.
    task automatic dataOp(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int n = 0;
        bit seen = 1'b0;
        bus.dReq = 1'b1; bus.dWr = wr; bus.dSize = size; bus.daddr = addr; bus.dwData = wdata;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.dAck) seen = 1'b1;
            else if (n == 1) begin
                bus.dWr = ~wr; bus.dSize = 2'($urandom); bus.daddr = $urandom; bus.dwData = $urandom;
            end
        end
        check("dLatency", n, LAT + 1);
        rdata = bus.drData;
        err   = bus.dErr;
        if (wr) modelStore(size, addr, wdata);
        bus.dReq = 1'b0;
        @(posedge clk); #1;
        check("dAckPulse", bus.dAck, 0);
    endtask

    task automatic fetchOp(input logic [31:0] addr, output logic [31:0] word);
        int n = 0;
        bit seen = 1'b0;
        bus.iReq = 1'b1; bus.iaddr = addr;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.iAck) seen = 1'b1;
            else if (n == 1) bus.iaddr = $urandom;
        end
        check("iLatency", n, LAT + 1);
        word = bus.inst;
        bus.iReq = 1'b0;
        @(posedge clk); #1;
        check("iAckPulse", bus.iAck, 0);
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, ".iAck"},   bus.iAck,   0);
        check({tag, ".dAck"},   bus.dAck,   0);
        check({tag, ".dErr"},   bus.dErr,   0);
        check({tag, ".inst"},   bus.inst,   0);
        check({tag, ".drData"}, bus.drData, 0);
    endtask

    initial begin
        logic [31:0] r, w, prev, expD;
        logic        e, wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] byteExp [4];
        int          dAt, iAt, kind;
        logic [31:0] dVal, iVal;
        bit          anyAck;

        bus.iReq = 1'b0; bus.iaddr = 32'd0;
        bus.dReq = 1'b0; bus.dWr = 1'b0; bus.dSize = 2'd0; bus.daddr = 32'd0; bus.dwData = 32'd0;
        pcRst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutputsZero("reset");
        pcRst = 1'b1;
        @(posedge clk); #1;

        // Give every word in the low 256 bytes a known nonzero value.
        for (int i = 0; i < 64; i++) begin
            w = $urandom | 32'h0000_0101;
            dataOp(1'b1, 2'd2, 32'(i * 4), w, r, e);
        end

        dataOp(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, r, e);
        check("wordStoreErr", e, 0);
        dataOp(1'b0, 2'd2, 32'h10, 32'd0, r, e);
        check("wordLoad", r, 32'hDEAD_BEEF);
        check("wordLoadErr", e, 0);

        dataOp(1'b1, 2'd2, 32'h20, 32'h1122_3344, r, e);
        byteExp = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            dataOp(1'b0, 2'd0, 32'(32'h20 + i), 32'd0, r, e);
            check("byteLoad", r, byteExp[i]);
        end
        dataOp(1'b0, 2'd1, 32'h22, 32'd0, r, e);
        check("halfLoad", r, 32'h3344);
        dataOp(1'b1, 2'd0, 32'h21, 32'h0000_00AA, r, e);
        dataOp(1'b0, 2'd2, 32'h20, 32'd0, r, e);
        check("byteStoreMerge", r, 32'h11AA_3344);

        prev = modelWord(32'h30);
        dataOp(1'b1, 2'd2, 32'h31, 32'hFFFF_FFFF, r, e);
        check("misStoreErr", e, 1);
        check("misStoreData", r, 0);
        dataOp(1'b0, 2'd2, 32'h30, 32'd0, r, e);
        check("misStoreUnchanged", r, prev);
        dataOp(1'b0, 2'd1, 32'h23, 32'd0, r, e);
        check("misHalfErr", e, 1);
        check("misHalfData", r, 0);

        // Simultaneous requests: data wins, fetch is deferred until the data access retires.
        bus.iReq = 1'b1; bus.iaddr = 32'h0;
        bus.dReq = 1'b1; bus.dWr = 1'b0; bus.dSize = 2'd2; bus.daddr = 32'h40;
        dAt = 0; iAt = 0; dVal = 32'd0; iVal = 32'd0;
        for (int n = 1; n <= 40 && iAt == 0; n++) begin
            @(posedge clk); #1;
            if (bus.dAck) begin dAt = n; dVal = bus.drData; bus.dReq = 1'b0; end
            if (bus.iAck) begin iAt = n; iVal = bus.inst;  bus.iReq = 1'b0; end
        end
        bus.dReq = 1'b0; bus.iReq = 1'b0;
        check("simulDAt", dAt, LAT + 1);
        check("simulIAt", iAt, 2 * LAT + 3);
        check("simulDData", dVal, modelWord(32'h40));
        check("simulInst", iVal, modelWord(32'h0));
        @(posedge clk); #1;

        // Reset while the store is in flight.
        prev = modelWord(32'h50);
        bus.dReq = 1'b1; bus.dWr = 1'b1; bus.dSize = 2'd2; bus.daddr = 32'h50; bus.dwData = 32'h1234_5678;
        @(posedge clk); #1;
        pcRst = 1'b0;
        #1;
        checkOutputsZero("midReset");
        bus.dReq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pcRst = 1'b1;
        anyAck = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.dAck || bus.iAck) anyAck = 1'b1;
        end
        check("noAckAfterReset", anyAck, 0);
        dataOp(1'b0, 2'd2, 32'h50, 32'd0, r, e);
        check("resetNoWrite", r, prev);

        dataOp(1'b1, 2'd2, 32'h1004, 32'hCAFE_F00D, r, e);
        dataOp(1'b0, 2'd2, 32'h0004, 32'd0, r, e);
        check("addrWrap", r, 32'hCAFE_F00D);

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 3);
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            if (kind == 3) begin
                expD = modelWord(addr);
                fetchOp(addr, r);
                check("rndFetch", r, expD);
            end else begin
                wr   = (kind == 1);
                size = 2'($urandom_range(0, 3));
                w    = $urandom;
                expD = modelLoad(size, addr);
                dataOp(wr, size, addr, w, r, e);
                check("rndErr", e, 32'(modelMis(size, addr)));
                if (!wr || modelMis(size, addr))
                    check("rndData", r, wr ? 32'd0 : expD);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
